ecc_serial_host: RTL and testbench
==================================

// Module: ecc_serial_host
// PURPOSE
//  Host-side end of the ECC bit-serial link. Takes one parallel ECDH job, serialises
//  mode + operands onto the core's input lines, deserialises mP, then sends nP and
//  deserialises mnP. Returns all four coordinates on a valid/ready response port.
//  Sits between the SoC/bench register interface and the ECC core top.
// PARAMETERS
//  MAX_BITS        256     operand register width; fields are LSB-aligned
//  TIMEOUT_CYCLES  1<<20   wait-state limit in cycles; used only with ECC_HOST_TIMEOUT_EN
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         asynchronous, active-low reset
//  req_valid      in   1         job request
//  req_ready      out  1         high only in IDLE
//  req_mode       in   2         00=32, 01=64, 10=128, 11=256 bits (N)
//  req_a/b/prime  in   MAX_BITS  curve coefficients and field prime
//  req_px/py/m    in   MAX_BITS  base point and scalar m
//  req_npx/npy    in   MAX_BITS  peer point nP
//  rsp_valid      out  1         results valid; held until rsp_ready
//  rsp_ready      in   1         response accept
//  rsp_mpx/mpy    out  MAX_BITS  captured mP; bits above N are zero
//  rsp_mnpx/mnpy  out  MAX_BITS  captured mnP; bits above N are zero
//  rsp_err        out  1         timeout flag; tied 0 without the macro
//  o_m_P_valid    out  1         1-cycle job-start pulse to the core
//  o_nP_valid     out  1         1-cycle nP-start pulse to the core
//  o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy  out 1 each  serial data, MSB first
//  i_mP_valid, i_mPx, i_mPy      in  1 each  serial mP from the core; MSB arrives with the first valid
//  i_mnP_valid, i_mnPx, i_mnPy   in  1 each  serial mnP from the core
// BEHAVIOUR
//  - Reset: state=IDLE. All o_* serial outputs, rsp_valid, rsp_err and rsp_* data are 0.
//    req_ready reads 1 while in IDLE.
//  - All serial outputs are registered. They drive 0 in every cycle where they do not carry data.
//  - FSM transitions:
//    IDLE -> HDR -> SEND_MP -> WAIT_MP -> RECV_MP -> NP_HDR -> SEND_NP -> WAIT_MNP -> RECV_MNP -> DONE -> IDLE
//  - IDLE: on accept (req_valid&&req_ready, cycle T), latch all req_* fields and N.
//  - HDR: o_m_P_valid=1 at T+1. o_mode=req_mode[1] at T+2 and req_mode[0] at T+3.
//  - SEND_MP: cycles T+4..T+N+3 carry bit N-1-k of a, b, prime, Px, Py and m in parallel.
//    A down-counter is loaded with N-1.
//  - WAIT_MP: wait for i_mP_valid.
//  - RECV_MP: capture on each cycle with i_mP_valid=1, shifting left into the LSB.
//    Complete after exactly N valid cycles. Gaps in valid pause capture. Valid bits beyond N are ignored.
//  - nP is sent only after mP is fully captured, so the core never sees nP before the mP computation.
//  - NP_HDR: 1 cycle with o_nP_valid=1.
//  - SEND_NP: the next N cycles carry nPx/nPy MSB first.
//  - WAIT_MNP / RECV_MNP: same capture rules as mP, using the i_mnP_* inputs.
//  - DONE: rsp_valid=1 with data stable. On rsp_valid&&rsp_ready -> IDLE; req_ready rises the next cycle.
//  - i_mP_valid or i_mnP_valid outside its WAIT/RECV state is ignored.
//  - req_valid while busy is not accepted (req_ready=0).
//  - Reset mid-operation: immediate return to reset state; the partial job is discarded.
//  - Counters are 8 bits wide (N-1 max 255). N=128 sends exactly 128 bits.
// CONFIGURATION
//  ECC_HOST_TIMEOUT_EN defined:
//  - A cycle counter runs in WAIT_MP, RECV_MP, WAIT_MNP and RECV_MNP.
//  - It is cleared when the state changes.
//  - Reaching TIMEOUT_CYCLES -> DONE with rsp_err=1; uncaptured results read 0.
//  ECC_HOST_TIMEOUT_EN undefined:
//  - No counter; the FSM waits indefinitely.
//  - rsp_err is constant 0.
// STRUCTURE
//  - Package ecc_host_pkg: MAX_BITS default, mode encodings BITS32..BITS256,
//    FSM state enum, function mode_to_nbits().
//  - Sub-module ecc_sipo_capture, instantiated twice (mP, mnP):
//    valid-gated 2-lane shift-in with bit counter and done flag.
// TESTING
//  1. Job mode=00, a=2, b=3, p=97, P=(3,6), m=2; bench model returns (80,10) for mP.
//     -> o_m_P_valid at T+1, mode bits 0,0, then 32 operand bits MSB first; rsp_mpx=80, rsp_mpy=10.
//  2. Same job with nP=(80,10); model returns mnP=(x,y).
//     -> o_nP_valid one cycle after the last mP bit is captured; rsp_mnp* equals the model output.
//  3. mode=11 with operands 0x8000...0001.
//     -> exactly 256 bits sent, first bit=1, last bit=1.
//  4. mode=10: exactly 128 operand cycles.
//     i_mP_valid with 3-cycle gaps mid-stream -> captured value is unaffected.
//  5. rst low during SEND_MP -> all o_* = 0 immediately; new job then runs normally.
//     rsp_ready held low 10 cycles -> rsp_valid and data stable.
//  6. (ECC_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100) core never asserts i_mP_valid
//     -> rsp_valid with rsp_err=1 at wait cycle 100.

Source files
------------

// File: rtl/ecc_host_pkg.sv
// ecc_host_pkg: shared width default, mode encodings, FSM states and mode decode for the ECC serial host.
package ecc_host_pkg;
    localparam int DEFAULT_MAX_BITS = 256;
    typedef enum logic [1:0] {BITS32 = 2'b00, BITS64 = 2'b01, BITS128 = 2'b10, BITS256 = 2'b11} mode_t;
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_SEND_MP, S_WAIT_MP, S_RECV_MP,
        S_NP_HDR, S_SEND_NP, S_WAIT_MNP, S_RECV_MNP, S_DONE
    } state_t;
    function automatic logic [8:0] mode_to_nbits(input logic [1:0] mode);
        return 9'd32 << mode;
    endfunction
endpackage

// File: rtl/ecc_sipo_capture.sv
// ecc_sipo_capture: valid-gated two-lane MSB-first shift-in with bit counter and done flag.
module ecc_sipo_capture
    import ecc_host_pkg::*;
#(
    parameter int MAX_BITS = DEFAULT_MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                valid,
    input  logic                x_in,
    input  logic                y_in,
    input  logic [7:0]          last_idx,
    output logic                last,
    output logic [MAX_BITS-1:0] x,
    output logic [MAX_BITS-1:0] y
);
    logic [7:0] cnt;
    logic done;
    logic take;
    logic [MAX_BITS-1:0] x_sr, y_sr;
    assign take = en && valid && !done;
    assign last = take && cnt == last_idx;
    // A partial capture stays hidden so an aborted receive reads as zero.
    assign x = done ? x_sr : '0;
    assign y = done ? y_sr : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            done <= 1'b0;
            x_sr <= '0;
            y_sr <= '0;
        end else if (clr) begin
            cnt <= '0;
            done <= 1'b0;
            x_sr <= '0;
            y_sr <= '0;
        end else if (take) begin
            x_sr <= {x_sr[MAX_BITS-2:0], x_in};
            y_sr <= {y_sr[MAX_BITS-2:0], y_in};
            cnt <= cnt + 8'd1;
            done <= cnt == last_idx;
        end
    end
endmodule

// File: rtl/ecc_serial_host.sv
// ecc_serial_host: host end of the ECC bit-serial link; define ECC_HOST_TIMEOUT_EN for the wait-state timeout.
module ecc_serial_host
  import ecc_host_pkg::*;
#(
  parameter int MAX_BITS = DEFAULT_MAX_BITS,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_mode,
  input  logic [MAX_BITS-1:0] req_a,
  input  logic [MAX_BITS-1:0] req_b,
  input  logic [MAX_BITS-1:0] req_prime,
  input  logic [MAX_BITS-1:0] req_px,
  input  logic [MAX_BITS-1:0] req_py,
  input  logic [MAX_BITS-1:0] req_m,
  input  logic [MAX_BITS-1:0] req_npx,
  input  logic [MAX_BITS-1:0] req_npy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_mpx,
  output logic [MAX_BITS-1:0] rsp_mpy,
  output logic [MAX_BITS-1:0] rsp_mnpx,
  output logic [MAX_BITS-1:0] rsp_mnpy,
  output logic                rsp_err,
  output logic                o_m_P_valid,
  output logic                o_nP_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nPx,
  output logic                o_nPy,
  input  logic                i_mP_valid,
  input  logic                i_mPx,
  input  logic                i_mPy,
  input  logic                i_mnP_valid,
  input  logic                i_mnPx,
  input  logic                i_mnPy
);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, last_idx;
  logic [1:0] mode_q;
  logic [MAX_BITS-1:0] a_q, b_q, p_q, px_q, py_q, m_q, npx_q, npy_q;
  logic [10:0] ser, ser_n;
  logic accept, mp_last, mnp_last, timeout;
  assign last_idx = 8'(mode_to_nbits(mode_q) - 9'd1);
  assign req_ready = state == S_IDLE;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == S_DONE;
  assign {o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy} = ser;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (accept) begin
        state_n = S_HDR;
        cnt_n = 8'd2;
      end
      S_HDR: begin
        cnt_n = cnt == 8'd0 ? last_idx : cnt - 8'd1;
        if (cnt == 8'd0) state_n = S_SEND_MP;
      end
      S_SEND_MP: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd0) state_n = S_WAIT_MP;
      end
      S_WAIT_MP: if (i_mP_valid) state_n = S_RECV_MP;
      S_RECV_MP: if (mp_last) state_n = S_NP_HDR;
      S_NP_HDR: begin
        state_n = S_SEND_NP;
        cnt_n = last_idx;
      end
      S_SEND_NP: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd0) state_n = S_WAIT_MNP;
      end
      S_WAIT_MNP: if (i_mnP_valid) state_n = S_RECV_MNP;
      S_RECV_MNP: if (mnp_last) state_n = S_DONE;
      S_DONE: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (timeout) state_n = S_DONE;
  end
  always_comb begin
    ser_n = '0;
    case (state_n)
      S_HDR: ser_n = cnt_n == 8'd2 ? 11'h400 : {2'b0, mode_q[cnt_n[0]], 8'b0};
      S_SEND_MP: ser_n = {3'b0, a_q[cnt_n], b_q[cnt_n], p_q[cnt_n], px_q[cnt_n], py_q[cnt_n], m_q[cnt_n], 2'b0};
      S_NP_HDR: ser_n = 11'h200;
      S_SEND_NP: ser_n = {9'b0, npx_q[cnt_n], npy_q[cnt_n]};
      default: ser_n = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      ser <= '0;
      mode_q <= '0;
      {a_q, b_q, p_q, px_q, py_q, m_q, npx_q, npy_q} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ser <= ser_n;
      if (accept) begin
        mode_q <= req_mode;
        {a_q, b_q, p_q, px_q, py_q, m_q, npx_q, npy_q} <=
          {req_a, req_b, req_prime, req_px, req_py, req_m, req_npx, req_npy};
      end
    end
  end
  ecc_sipo_capture #(.MAX_BITS(MAX_BITS)) u_mp (
    .clk(clk), .rst(rst), .clr(accept),
    .en(state == S_WAIT_MP || state == S_RECV_MP),
    .valid(i_mP_valid), .x_in(i_mPx), .y_in(i_mPy), .last_idx(last_idx),
    .last(mp_last), .x(rsp_mpx), .y(rsp_mpy)
  );
  ecc_sipo_capture #(.MAX_BITS(MAX_BITS)) u_mnp (
    .clk(clk), .rst(rst), .clr(accept),
    .en(state == S_WAIT_MNP || state == S_RECV_MNP),
    .valid(i_mnP_valid), .x_in(i_mnPx), .y_in(i_mnPy), .last_idx(last_idx),
    .last(mnp_last), .x(rsp_mnpx), .y(rsp_mnpy)
  );
`ifdef ECC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
  logic waiting, err;
  assign waiting = state inside {S_WAIT_MP, S_RECV_MP, S_WAIT_MNP, S_RECV_MNP};
  assign timeout = waiting && wait_cnt == T_LAST;
  assign rsp_err = err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err <= 1'b0;
    end else begin
      wait_cnt <= (!waiting || state_n != state) ? '0 : wait_cnt + 1'b1;
      err <= accept ? 1'b0 : (timeout ? 1'b1 : err);
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_ecc_serial_host.sv
// tb_ecc_serial_host: randomized jobs against a bench-side serial link model acting as the ECC core.
module tb_ecc_serial_host;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_mode = '0;
  logic [255:0] req_a = '0, req_b = '0, req_prime = '0, req_px = '0, req_py = '0, req_m = '0, req_npx = '0, req_npy = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [255:0] rsp_mpx, rsp_mpy, rsp_mnpx, rsp_mnpy;
  logic o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy;
  logic i_mP_valid = 1'b0, i_mPx = 1'b0, i_mPy = 1'b0, i_mnP_valid = 1'b0, i_mnPx = 1'b0, i_mnPy = 1'b0;
  logic [10:0] ser, e_ser;
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  logic [255:0] op [8];
  logic [255:0] res [4];
  logic [255:0] exp_res [4];
  logic exp_ready = 1'b1, exp_rsp_valid = 1'b0, exp_err = 1'b0;
  logic [10:0] exp_q [$];
`ifdef ECC_HOST_TIMEOUT_EN
  int max_mode = 0;
`else
  int max_mode = 3;
`endif
  always #5 clk = ~clk;
  assign ser = {o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy};
  ecc_serial_host #(.MAX_BITS(256), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b), .req_prime(req_prime), .req_px(req_px), .req_py(req_py),
    .req_m(req_m), .req_npx(req_npx), .req_npy(req_npy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mpx(rsp_mpx), .rsp_mpy(rsp_mpy),
    .rsp_mnpx(rsp_mnpx), .rsp_mnpy(rsp_mnpy), .rsp_err(rsp_err),
    .o_m_P_valid(o_m_P_valid), .o_nP_valid(o_nP_valid), .o_mode(o_mode), .o_a(o_a), .o_b(o_b),
    .o_prime(o_prime), .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m), .o_nPx(o_nPx), .o_nPy(o_nPy),
    .i_mP_valid(i_mP_valid), .i_mPx(i_mPx), .i_mPy(i_mPy),
    .i_mnP_valid(i_mnP_valid), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy)
  );
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit lane, input logic v, input logic x, input logic y);
    if (lane) {i_mnP_valid, i_mnPx, i_mnPy} = {v, x, y};
    else {i_mP_valid, i_mPx, i_mPy} = {v, x, y};
  endtask
  task automatic rand_job();
    for (int i = 0; i < 8; i++) op[i] = rnd256();
    for (int i = 0; i < 4; i++) res[i] = rnd256();
  endtask
  task automatic start_job(input logic [1:0] mode);
    int n;
    n = 32 << mode;
    {req_a, req_b, req_prime, req_px, req_py, req_m, req_npx, req_npy} =
      {op[0], op[1], op[2], op[3], op[4], op[5], op[6], op[7]};
    req_mode = mode;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_mode = 2'($urandom);
    {req_a, req_b, req_prime, req_px} = {rnd256(), rnd256(), rnd256(), rnd256()};
    {req_py, req_m, req_npx, req_npy} = {rnd256(), rnd256(), rnd256(), rnd256()};
    exp_ready = 1'b0;
    exp_q.push_back(11'h400);
    exp_q.push_back({2'b0, mode[1], 8'b0});
    exp_q.push_back({2'b0, mode[0], 8'b0});
    for (int k = 0; k < n; k++)
      exp_q.push_back({3'b0, op[0][n-1-k], op[1][n-1-k], op[2][n-1-k],
                       op[3][n-1-k], op[4][n-1-k], op[5][n-1-k], 2'b0});
  endtask
  task automatic send_res(input bit lane, input int n, input bit gaps);
    int g = 0;
    repeat ($urandom_range(0, 3)) step();
    for (int k = 0; k < n; k++) begin
      if (gaps && g < 4 && $urandom_range(0, 15) == 0) begin
        g++;
        repeat (3) step();
      end
      drive(lane, 1'b1, res[2*lane][n-1-k], res[2*lane+1][n-1-k]);
      step();
      drive(lane, 1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic run_job(input logic [1:0] mode, input bit gaps);
    int n;
    logic [255:0] mask;
    n = 32 << mode;
    mask = (n == 256) ? '1 : (256'd1 << n) - 256'd1;
    start_job(mode);
    repeat (n + 3) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      req_valid = 1'($urandom);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0;
    send_res(1'b0, n, gaps);
    exp_q.push_back(11'h200);
    for (int k = 0; k < n; k++) exp_q.push_back({9'b0, op[6][n-1-k], op[7][n-1-k]});
    drive(1'b0, 1'b1, 1'($urandom), 1'($urandom));
    repeat (2) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n - 1) step();
    send_res(1'b1, n, gaps);
    for (int i = 0; i < 4; i++) exp_res[i] = res[i] & mask;
    exp_err = 1'b0;
    exp_rsp_valid = 1'b1;
    drive(1'b1, 1'b1, 1'($urandom), 1'($urandom));
    repeat (2) step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic finish_rsp(input int hold);
    repeat (hold) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask
  always @(negedge clk) begin
    if (checking) begin
      if (exp_q.size() > 0) e_ser = exp_q.pop_front();
      else e_ser = '0;
      check("serial", ser, e_ser);
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) begin
        check("rsp_err", rsp_err, exp_err);
        check("rsp_mpx", rsp_mpx, exp_res[0]);
        check("rsp_mpy", rsp_mpy, exp_res[1]);
        check("rsp_mnpx", rsp_mnpx, exp_res[2]);
        check("rsp_mnpy", rsp_mnpy, exp_res[3]);
      end
    end
  end
  initial begin
    repeat (2) step();
    check("reset_serial", ser, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_mpx", rsp_mpx, 0);
    check("reset_rsp_mnpy", rsp_mnpy, 0);
    rst = 1'b1;
    checking = 1'b1;
    step();
    op[0] = 256'd2; op[1] = 256'd3; op[2] = 256'd97; op[3] = 256'd3;
    op[4] = 256'd6; op[5] = 256'd2; op[6] = 256'd80; op[7] = 256'd10;
    res[0] = 256'd80; res[1] = 256'd10; res[2] = 256'd3; res[3] = 256'd91;
    run_job(2'b00, 1'b0);
    check("t1_mpx", rsp_mpx, 256'd80);
    check("t1_mpy", rsp_mpy, 256'd10);
    check("t2_mnpx", rsp_mnpx, 256'd3);
    check("t2_mnpy", rsp_mnpy, 256'd91);
    finish_rsp(1);
    rand_job();
    res[0] = '1;
    run_job(2'b00, 1'b1);
    check("mask_mpx", rsp_mpx, 256'hFFFF_FFFF);
    finish_rsp(0);
`ifndef ECC_HOST_TIMEOUT_EN
    rand_job();
    for (int i = 0; i < 8; i++) op[i] = {1'b1, 254'b0, 1'b1};
    run_job(2'b11, 1'b0);
    finish_rsp(0);
    rand_job();
    run_job(2'b10, 1'b1);
    finish_rsp(3);
`endif
    rand_job();
    start_job(2'b00);
    repeat (8) step();
    rst = 1'b0;
    exp_q.delete();
    exp_ready = 1'b1;
    #1;
    check("midrst_serial", ser, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    step();
    rst = 1'b1;
    step();
    rand_job();
    run_job(2'b00, 1'b0);
    finish_rsp(10);
    repeat (6) begin
      rand_job();
      run_job(2'($urandom_range(0, max_mode)), 1'($urandom));
      finish_rsp($urandom_range(0, 4));
    end
`ifdef ECC_HOST_TIMEOUT_EN
    rand_job();
    start_job(2'b00);
    repeat (35 + 100) step();
    exp_err = 1'b1;
    for (int i = 0; i < 4; i++) exp_res[i] = '0;
    exp_rsp_valid = 1'b1;
    check("timeout_err", rsp_err, 1);
    finish_rsp(2);
`endif
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
